prefetch_queue: RTL and testbench

Byte-granular code queue directly downstream of the instruction cache read path. It accepts 1–4-byte code entries on the prefetch-FIFO write port. It presents the oldest bytes to the decoder as a 16-byte little-endian window, with a valid count. The decoder consumes 1–15 bytes per cycle. The queue reports free space so the prefetch unit can cap its cache read lengths. It carries a fault marker that stops further fills until flush.

---
 rtl/prefetch_queue_pkg.sv | 32 +++
 rtl/prefetch_queue_window.sv | 40 ++++
 rtl/prefetch_queue.sv | 143 ++++++++++++++
 tb/tb_prefetch_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_pkg.sv
// rtl/prefetch_queue_pkg.sv - shared constants, entry layout and length classification for prefetch_queue
package prefetch_queue_pkg;

  localparam int PQ_DEPTH_BYTES  = 32;
  localparam int PQ_WINDOW_BYTES = 16;

  localparam int PQ_ENTRY_W  = 36;
  localparam int PQ_LEN_MSB  = 35;
  localparam int PQ_LEN_LSB  = 32;
  localparam int PQ_DATA_MSB = 31;
  localparam int PQ_DATA_LSB = 0;

  localparam int         PQ_MAX_ENTRY_BYTES = 4;
  localparam logic [3:0] PQ_LEN_FAULT       = 4'hF;

  typedef enum logic [1:0] {
    PQ_LEN_DATA,
    PQ_LEN_MARK,
    PQ_LEN_BAD
  } pq_len_class_e;

  function automatic pq_len_class_e pq_classify(input logic [3:0] len);
    if (len == PQ_LEN_FAULT) begin
      return PQ_LEN_MARK;
    end else if ((len >= 4'd1) && (len <= 4'(PQ_MAX_ENTRY_BYTES))) begin
      return PQ_LEN_DATA;
    end else begin
      return PQ_LEN_BAD;
    end
  endfunction

endpackage

// File: rtl/prefetch_queue_window.sv
// rtl/prefetch_queue_window.sv - registered rotator presenting WINDOW_BYTES bytes from the circular store
module prefetch_queue_window
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH_BYTES  = PQ_DEPTH_BYTES,
  parameter int WINDOW_BYTES = PQ_WINDOW_BYTES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear_i,
  input  logic [DEPTH_BYTES*8-1:0]           mem_i,
  input  logic [$clog2(DEPTH_BYTES)-1:0]     rd_ptr_i,
  output logic [WINDOW_BYTES*8-1:0]          window_o
);

  localparam int SW = $clog2(2 * DEPTH_BYTES * 8);

  logic [2*DEPTH_BYTES*8-1:0] dbl;
  logic [SW-1:0]              sel;
  logic [WINDOW_BYTES*8-1:0]  window_d;
  logic [WINDOW_BYTES*8-1:0]  window_q;

  // Doubling the store lets a single part-select cover windows that wrap past the last byte.
  always_comb begin
    dbl      = {mem_i, mem_i};
    sel      = SW'({rd_ptr_i, 3'b000});
    window_d = dbl[sel +: WINDOW_BYTES*8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      window_q <= '0;
    end else begin
      window_q <= window_d;
    end
  end

  assign window_o = window_q;

endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte-granular code queue feeding the decoder window from prefetch-FIFO entries
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH_BYTES  = PQ_DEPTH_BYTES,
  parameter int WINDOW_BYTES = PQ_WINDOW_BYTES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pr_reset,
  input  logic                               prefetchfifo_write_do,
  input  logic [PQ_ENTRY_W-1:0]              prefetchfifo_write_data,
  output logic [$clog2(DEPTH_BYTES):0]       prefetchfifo_free,
  output logic [WINDOW_BYTES*8-1:0]          window_bytes,
  output logic [$clog2(WINDOW_BYTES):0]      window_count,
  output logic                               fault_pending,
  input  logic                               consume_do,
  input  logic [3:0]                         consume_length,
  output logic                               protocol_error
);

  localparam int PW  = $clog2(DEPTH_BYTES);
  localparam int CW  = PW + 1;
  localparam int WCW = $clog2(WINDOW_BYTES) + 1;

  logic [DEPTH_BYTES*8-1:0] mem_q, mem_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, tail, idx;
  logic [CW-1:0]            count_q, count_d, count_after, free_after;
  logic [CW-1:0]            free_q, free_d;
  logic [WCW-1:0]           wcnt_q, wcnt_d, wcnt_cur, cons_amt;
  logic                     fault_q, fault_d, error_q, error_d;
  logic                     err_set, fault_set, wr_acc;
  logic [3:0]               wr_len;
  logic [31:0]              wr_data;
  pq_len_class_e            wr_class;

  function automatic logic [WCW-1:0] win_count(input logic [CW-1:0] c);
    return (c > CW'(WINDOW_BYTES)) ? WCW'(WINDOW_BYTES) : WCW'(c);
  endfunction

  always_comb begin
    wcnt_cur  = win_count(count_q);
    wr_len    = prefetchfifo_write_data[PQ_LEN_MSB:PQ_LEN_LSB];
    wr_data   = prefetchfifo_write_data[PQ_DATA_MSB:PQ_DATA_LSB];
    wr_class  = pq_classify(wr_len);
    cons_amt  = '0;
    err_set   = 1'b0;
    fault_set = 1'b0;
    wr_acc    = 1'b0;
    idx       = '0;

    // Illegal consume lengths still drain what the decoder can see, then flag the violation.
    if (consume_do) begin
      if ((consume_length == 4'd0) || (WCW'(consume_length) > wcnt_cur)) begin
        cons_amt = wcnt_cur;
        err_set  = 1'b1;
      end else begin
        cons_amt = WCW'(consume_length);
      end
    end

    count_after = count_q - CW'(cons_amt);
    free_after  = CW'(DEPTH_BYTES) - count_after;

    if (prefetchfifo_write_do && !fault_q) begin
      unique case (wr_class)
        PQ_LEN_MARK: fault_set = 1'b1;
        PQ_LEN_DATA: begin
          if (CW'(wr_len) > free_after) begin
            err_set = 1'b1;
          end else begin
            wr_acc = 1'b1;
          end
        end
        default: err_set = 1'b1;
      endcase
    end

    // New bytes land at the pre-consume tail; consumed slots are already behind the new head.
    tail  = rd_ptr_q + count_q[PW-1:0];
    mem_d = mem_q;
    for (int i = 0; i < PQ_MAX_ENTRY_BYTES; i++) begin
      if (wr_acc && (4'(i) < wr_len)) begin
        idx = tail + PW'(i);
        mem_d[{idx, 3'b000} +: 8] = wr_data[i*8 +: 8];
      end
    end

    count_d  = count_after + (wr_acc ? CW'(wr_len) : '0);
    rd_ptr_d = rd_ptr_q + PW'(cons_amt);
    fault_d  = fault_q | fault_set;
    error_d  = error_q | err_set;

    if (pr_reset) begin
      mem_d    = '0;
      count_d  = '0;
      rd_ptr_d = '0;
      fault_d  = 1'b0;
      error_d  = 1'b0;
    end

    wcnt_d = win_count(count_d);
    free_d = fault_d ? '0 : (CW'(DEPTH_BYTES) - count_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      error_q  <= 1'b0;
      free_q   <= CW'(DEPTH_BYTES);
      wcnt_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      error_q  <= error_d;
      free_q   <= free_d;
      wcnt_q   <= wcnt_d;
    end
  end

  prefetch_queue_window #(
    .DEPTH_BYTES  (DEPTH_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (pr_reset),
    .mem_i    (mem_d),
    .rd_ptr_i (rd_ptr_d),
    .window_o (window_bytes)
  );

  assign prefetchfifo_free = free_q;
  assign window_count      = wcnt_q;
  assign fault_pending     = fault_q;
  assign protocol_error    = error_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - randomized self-checking bench for prefetch_queue against a byte-queue model
module tb_prefetch_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pr_reset;
  logic         wdo;
  logic [35:0]  wdata;
  logic [5:0]   free;
  logic [127:0] wbytes;
  logic [4:0]   wcnt;
  logic         fp;
  logic         cdo;
  logic [3:0]   clen;
  logic         perr;

  always #5 clk = ~clk;

  prefetch_queue dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .pr_reset                (pr_reset),
    .prefetchfifo_write_do   (wdo),
    .prefetchfifo_write_data (wdata),
    .prefetchfifo_free       (free),
    .window_bytes            (wbytes),
    .window_count            (wcnt),
    .fault_pending           (fp),
    .consume_do              (cdo),
    .consume_length          (clen),
    .protocol_error          (perr)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  bit mfault = 1'b0;
  bit merr   = 1'b0;
  bit mclr   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int wc_of();
    return (mq.size() > 16) ? 16 : mq.size();
  endfunction

  task automatic model_step();
    int wc;
    int n;
    int len;
    if (!rst_n || pr_reset) begin
      mq.delete();
      mfault = 1'b0;
      merr   = 1'b0;
      mclr   = 1'b1;
    end else begin
      mclr = 1'b0;
      wc   = wc_of();
      if (cdo) begin
        n = int'(clen);
        if (n == 0 || n > wc) begin
          n    = wc;
          merr = 1'b1;
        end
        repeat (n) void'(mq.pop_front());
      end
      if (wdo && !mfault) begin
        len = int'(wdata[35:32]);
        if (len == 15) begin
          mfault = 1'b1;
        end else if (len >= 1 && len <= 4) begin
          if (len > 32 - mq.size()) merr = 1'b1;
          else for (int i = 0; i < len; i++) mq.push_back(wdata[8*i +: 8]);
        end else begin
          merr = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [127:0] exp_w;
    logic [127:0] mask;
    int wc;
    wc    = wc_of();
    exp_w = '0;
    mask  = '0;
    for (int i = 0; i < wc; i++) begin
      exp_w[8*i +: 8] = mq[i];
      mask[8*i +: 8]  = 8'hFF;
    end
    chk("window_count", 128'(wcnt), 128'(wc));
    chk("free", 128'(free), mfault ? 128'(0) : 128'(32 - mq.size()));
    chk("fault_pending", 128'(fp), 128'(mfault));
    chk("protocol_error", 128'(perr), 128'(merr));
    chk("window_bytes", wbytes & mask, exp_w);
    if (mclr) chk("window_clear", wbytes, 128'(0));
  endtask

  task automatic step(input bit w, input logic [35:0] d, input bit c, input logic [3:0] cl, input bit fl);
    wdo      = w;
    wdata    = d;
    cdo      = c;
    clen     = cl;
    pr_reset = fl;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 36'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 36'h0, 1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    int nxt_w;
    int nxt_r;
    int len;
    int n;
    int wc;
    int budget;
    bit do_w;
    bit do_c;
    logic [35:0] d;
    logic [3:0] cl;

    rst_n = 1'b0; pr_reset = 1'b0; wdo = 1'b0; wdata = '0; cdo = 1'b0; clen = '0;
    step(1'b0, 36'h0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 36'h0, 1'b0, 4'd0, 1'b0);
    chk("reset_free", 128'(free), 128'(32));
    chk("reset_window", wbytes, 128'(0));
    rst_n = 1'b1;

    // Two entries land in order, little-endian
    step(1'b1, {4'd4, 32'h44332211}, 1'b0, 4'd0, 1'b0);
    step(1'b1, {4'd2, 32'h00006655}, 1'b0, 4'd0, 1'b0);
    chk("t1_count", 128'(wcnt), 128'(6));
    chk("t1_bytes", 128'(wbytes[47:0]), 128'(48'h665544332211));
    chk("t1_free", 128'(free), 128'(26));

    // Full boundary
    flush();
    for (int i = 0; i < 8; i++) step(1'b1, {4'd4, 32'hA0A0A0A0 + 32'(i)}, 1'b0, 4'd0, 1'b0);
    chk("t2_free", 128'(free), 128'(0));
    chk("t2_wcnt", 128'(wcnt), 128'(16));
    step(1'b1, {4'd1, 32'h000000EE}, 1'b0, 4'd0, 1'b0);
    chk("t2_overflow_err", 128'(perr), 128'(1));
    flush();
    chk("t2_flush_free", 128'(free), 128'(32));
    chk("t2_flush_err", 128'(perr), 128'(0));

    // Simultaneous consume and write
    step(1'b1, {4'd4, 32'h03020100}, 1'b0, 4'd0, 1'b0);
    step(1'b1, {4'd4, 32'h07060504}, 1'b0, 4'd0, 1'b0);
    step(1'b1, {4'd2, 32'h00000908}, 1'b0, 4'd0, 1'b0);
    step(1'b1, {4'd4, 32'h0D0C0B0A}, 1'b1, 4'd3, 1'b0);
    chk("t3_wcnt", 128'(wcnt), 128'(11));
    chk("t3_bytes", 128'(wbytes[87:0]), 128'(88'h0D0C0B0A09080706050403));

    // Wrap with an ordered byte stream
    flush();
    nxt_w = 0; nxt_r = 0; budget = 0;
    while (nxt_r < 40 && budget < 400) begin
      budget++;
      wc   = wc_of();
      do_c = (wc > 0) && ($urandom_range(0, 1) == 1);
      n    = do_c ? int'($urandom_range(1, (wc > 15) ? 15 : wc)) : 0;
      len  = int'($urandom_range(1, 4));
      if (len > 40 - nxt_w) len = 40 - nxt_w;
      do_w = (len > 0) && (len <= 32 - (mq.size() - n)) && ($urandom_range(0, 3) != 0);
      d    = {4'(len), 32'h0};
      for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(nxt_w + i);
      if (do_c) begin
        chk("wrap_head", 128'(wbytes[7:0]), 128'(8'(nxt_r)));
        chk("wrap_last", 128'(wbytes[8*(n-1) +: 8]), 128'(8'(nxt_r + n - 1)));
        nxt_r += n;
      end
      if (do_w) nxt_w += len;
      step(do_w, d, do_c, 4'(n), 1'b0);
    end
    chk("wrap_done", 128'(nxt_r), 128'(40));

    // Fault marker
    flush();
    step(1'b1, {4'd2, 32'h0000BBAA}, 1'b0, 4'd0, 1'b0);
    step(1'b1, {4'hF, 32'h0}, 1'b0, 4'd0, 1'b0);
    chk("t5_fault", 128'(fp), 128'(1));
    chk("t5_free", 128'(free), 128'(0));
    chk("t5_wcnt", 128'(wcnt), 128'(2));
    step(1'b1, {4'd4, 32'h12345678}, 1'b0, 4'd0, 1'b0);
    chk("t5_no_err", 128'(perr), 128'(0));
    chk("t5_wcnt_hold", 128'(wcnt), 128'(2));
    flush();
    chk("t5_fault_clr", 128'(fp), 128'(0));

    // Bad length and over-consume
    step(1'b1, {4'd6, 32'h11111111}, 1'b0, 4'd0, 1'b0);
    chk("t6_badlen", 128'(perr), 128'(1));
    step(1'b1, {4'd3, 32'h00332211}, 1'b0, 4'd0, 1'b0);
    step(1'b0, 36'h0, 1'b1, 4'd5, 1'b0);
    chk("t6_drain", 128'(wcnt), 128'(0));
    step(1'b0, 36'h0, 1'b1, 4'd1, 1'b0);
    chk("t6_empty_wcnt", 128'(wcnt), 128'(0));
    chk("t6_err_sticky", 128'(perr), 128'(1));
    flush();
    chk("t6_err_clr", 128'(perr), 128'(0));

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      wc = wc_of();
      do_c = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) cl = 4'($urandom_range(0, 15));
      else cl = 4'((wc == 0) ? 1 : $urandom_range(1, (wc > 15) ? 15 : wc));
      do_w = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 39))
        0:       len = 15;
        1:       len = 6;
        2:       len = 0;
        default: len = int'($urandom_range(1, 4));
      endcase
      d = {4'(len), 32'($urandom)};
      step(do_w, d, do_c, cl, ($urandom_range(0, 49) == 0));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
